// File: rtl/rpn_stack_alu.sv
// rpn_stack_alu: RPN operand stack with 2-operand ALU and edge-triggered commands; define RPN_UNDO_EN for one-level undo
module rpn_stack_alu #(
  parameter int W = 16,
  parameter int DEPTH = 8
) (
  input  logic                         clk,
  input  logic                         resetN,
  input  logic                         Enter,
  input  logic                         Op,
  input  logic                         Undo,
  input  logic [W-1:0]                 DataIn,
  output logic [W-1:0]                 Top,
  output logic [3:0]                   Flags,
  output logic [$clog2(DEPTH+1)-1:0]   Count,
  output logic                         Error
);
  localparam int CW = $clog2(DEPTH+1);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] stk [DEPTH];
  logic [CW-1:0] cnt;
  logic enter_q, op_q, undo_q, live, c_f, v_f, err;
  logic [AW-1:0] tos_i, nos_i;
  logic [W-1:0] tos, nos, res;
  logic [W:0] sum, diff;
  logic [2:0] opc;
  logic undo_e, op_e, enter_e, op_ok, c_n, v_n;
`ifdef RPN_UNDO_EN
  typedef enum logic [1:0] {H_NONE, H_PUSH, H_OP} hist_t;
  hist_t hist;
  logic [W-1:0] h_nos, h_tos;
  logic [CW-1:0] h_cnt;
`endif
  // live masks the first cycle after reset so a level held through release is not an edge
  assign undo_e  = live & Undo & ~undo_q;
  assign op_e    = live & Op & ~op_q & ~undo_e;
  assign enter_e = live & Enter & ~enter_q & ~op_e & ~undo_e;
  assign tos_i = AW'(cnt - CW'(1));
  assign nos_i = AW'(cnt - CW'(2));
  assign tos = stk[tos_i];
  assign nos = stk[nos_i];
  assign opc = DataIn[2:0];
  assign sum  = {1'b0, nos} + {1'b0, tos};
  assign diff = {1'b0, nos} - {1'b0, tos};
  assign op_ok = cnt >= CW'(2) && opc <= 3'd5;
  always_comb begin
    res = opc == 3'd0 ? sum[W-1:0] : opc == 3'd1 ? diff[W-1:0] :
          opc == 3'd2 ? nos & tos : opc == 3'd3 ? nos | tos : nos ^ tos;
    c_n = opc == 3'd0 ? sum[W] : opc == 3'd1 ? diff[W] : 1'b0;
    v_n = opc == 3'd0 ? (nos[W-1] == tos[W-1]) && (sum[W-1] != nos[W-1]) :
          opc == 3'd1 ? (nos[W-1] != tos[W-1]) && (diff[W-1] != nos[W-1]) : 1'b0;
  end
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      for (int i = 0; i < DEPTH; i++) stk[i] <= '0;
      cnt <= '0;
      {enter_q, op_q, undo_q, live, c_f, v_f, err} <= '0;
`ifdef RPN_UNDO_EN
      hist <= H_NONE;
      h_nos <= '0;
      h_tos <= '0;
      h_cnt <= '0;
`endif
    end else begin
      {enter_q, op_q, undo_q, live} <= {Enter, Op, Undo, 1'b1};
      if (undo_e) begin
`ifdef RPN_UNDO_EN
        if (hist == H_NONE) err <= 1'b1;
        else begin
          if (hist == H_PUSH) cnt <= cnt - CW'(1);
          else begin
            stk[AW'(h_cnt - CW'(2))] <= h_nos;
            stk[AW'(h_cnt - CW'(1))] <= h_tos;
            cnt <= h_cnt;
          end
          hist <= H_NONE;
          {c_f, v_f, err} <= '0;
        end
`endif
      end else if (op_e) begin
        if (!op_ok) err <= 1'b1;
        else begin
          {c_f, v_f, err} <= {c_n, v_n, 1'b0};
          if (opc == 3'd5) begin
            stk[nos_i] <= tos;
            stk[tos_i] <= nos;
          end else begin
            stk[nos_i] <= res;
            cnt <= cnt - CW'(1);
          end
`ifdef RPN_UNDO_EN
          hist <= H_OP;
          h_nos <= nos;
          h_tos <= tos;
          h_cnt <= cnt;
`endif
        end
      end else if (enter_e) begin
        if (cnt == CW'(DEPTH)) err <= 1'b1;
        else begin
          stk[AW'(cnt)] <= DataIn;
          cnt <= cnt + CW'(1);
          {c_f, v_f, err} <= '0;
`ifdef RPN_UNDO_EN
          hist <= H_PUSH;
`endif
        end
      end
    end
  end
  assign Top = cnt == '0 ? '0 : tos;
  assign Count = cnt;
  assign Error = err;
  assign Flags = {Top[W-1], Top == '0 && cnt != '0, c_f, v_f};
endmodule

// File: tb/tb_rpn_stack_alu.sv
// tb_rpn_stack_alu: randomized and directed checks of rpn_stack_alu against a queue-based reference model
module tb_rpn_stack_alu;
  logic clk = 0;
  logic resetN = 1;
  logic Enter = 0, Op = 0, Undo = 0;
  logic [15:0] DataIn = '0;
  logic [15:0] Top;
  logic [3:0] Flags;
  logic [3:0] Count;
  logic Error;
  int n_tests = 0, n_fail = 0;
  logic [15:0] st[$], hs[$];
  bit hv, mc, mv, merr, fresh, pe, po, pu;

  rpn_stack_alu #(.W(16), .DEPTH(8)) dut (
    .clk(clk), .resetN(resetN), .Enter(Enter), .Op(Op), .Undo(Undo),
    .DataIn(DataIn), .Top(Top), .Flags(Flags), .Count(Count), .Error(Error)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic check_all(input string tag);
    logic [15:0] t;
    t = st.size() > 0 ? st[$] : 16'h0;
    chk({tag, ".top"}, 32'(Top), 32'(t));
    chk({tag, ".count"}, 32'(Count), 32'(st.size()));
    chk({tag, ".flags"}, 32'(Flags), 32'({t[15], t == 16'h0 && st.size() > 0, mc, mv}));
    chk({tag, ".error"}, 32'(Error), 32'(merr));
  endtask

  task automatic model(input bit e, input bit o, input bit u, input logic [15:0] d);
    logic [15:0] a, b, r;
    int sa, sb, s, opc;
    bit re, ro, ru;
    re = e && !pe; ro = o && !po; ru = u && !pu;
    pe = e; po = o; pu = u;
    if (fresh) begin
      fresh = 0;
      return;
    end
    opc = int'(d[2:0]);
    if (ru) begin
`ifdef RPN_UNDO_EN
      if (!hv) merr = 1;
      else begin
        st = hs; hv = 0; mc = 0; mv = 0; merr = 0;
      end
`endif
    end else if (ro) begin
      if (st.size() < 2 || opc > 5) merr = 1;
      else begin
        hs = st; hv = 1; merr = 0; mc = 0; mv = 0;
        b = st.pop_back();
        a = st.pop_back();
        sa = int'($signed(a)); sb = int'($signed(b));
        if (opc == 5) begin
          st.push_back(b);
          st.push_back(a);
        end else begin
          if (opc == 0) begin
            r = a + b; mc = (32'(a) + 32'(b)) > 32'hFFFF;
            s = sa + sb; mv = s > 32767 || s < -32768;
          end else if (opc == 1) begin
            r = a - b; mc = a < b;
            s = sa - sb; mv = s > 32767 || s < -32768;
          end else r = opc == 2 ? (a & b) : opc == 3 ? (a | b) : (a ^ b);
          st.push_back(r);
        end
      end
    end else if (re) begin
      if (st.size() == 8) merr = 1;
      else begin
        hs = st; hv = 1; st.push_back(d); mc = 0; mv = 0; merr = 0;
      end
    end
  endtask

  task automatic cyc(input bit e, input bit o, input bit u, input logic [15:0] d, input string tag = "cyc");
    @(negedge clk);
    Enter = e; Op = o; Undo = u; DataIn = d;
    model(e, o, u, d);
    @(posedge clk);
    #1 check_all(tag);
  endtask

  task automatic cmd(input bit e, input bit o, input bit u, input logic [15:0] d, input string tag);
    cyc(e, o, u, d, tag);
    cyc(0, 0, 0, d, {tag, ".gap"});
  endtask

  task automatic do_reset(input bit e, input bit o, input bit u);
    Enter = e; Op = o; Undo = u;
    resetN = 0;
    st.delete(); hs.delete();
    hv = 0; mc = 0; mv = 0; merr = 0; fresh = 1;
    #1 check_all("rst");
    repeat (2) @(posedge clk);
    #1 resetN = 1;
    cyc(e, o, u, 16'h0, "rst.rel");
  endtask

  initial begin
    #2 do_reset(0, 0, 0);
    cmd(1, 0, 0, 16'hFFFF, "ent_ffff");
    cmd(1, 0, 0, 16'h005A, "ent_005a");
    cmd(0, 1, 0, 16'h0001, "op_sub");
    cmd(0, 0, 1, 16'h0000, "undo1");
    cmd(0, 0, 1, 16'h0000, "undo2");
    cmd(0, 1, 0, 16'h0005, "swap");
    cmd(0, 1, 0, 16'h0005, "swap_back");
    cmd(1, 0, 0, 16'h8000, "ent_8000a");
    cmd(1, 0, 0, 16'h8000, "ent_8000b");
    cmd(0, 1, 0, 16'h0000, "op_add_ovf");
    cmd(0, 1, 0, 16'h0007, "op_bad7");
    for (int i = 1; i <= 7; i++) cmd(1, 0, 0, 16'(i), "fill");
    cmd(1, 0, 0, 16'h0009, "full");
    cmd(0, 1, 0, 16'h0000, "add_after_full");
    cyc(1, 1, 1, 16'h0002, "simul");
    cyc(1, 0, 0, 16'h0002, "hold1");
    cyc(1, 0, 0, 16'h0002, "hold2");
    cyc(0, 0, 0, 16'h0002, "hold_rel");
    do_reset(0, 0, 0);
    cmd(1, 0, 0, 16'h1234, "one");
    cmd(0, 1, 0, 16'h0000, "add_cnt1");
    cmd(0, 0, 1, 16'h0000, "undo_push");
    do_reset(1, 0, 0);
    cyc(1, 0, 0, 16'h4444, "held_rst1");
    cyc(1, 0, 0, 16'h4444, "held_rst2");
    cmd(0, 0, 0, 16'h0, "held_drop");
    cmd(1, 0, 0, 16'h4444, "push_after");
    for (int i = 0; i < 1500; i++) begin
      bit e, o, u;
      logic [15:0] d;
      e = $urandom_range(0, 2) == 0;
      o = $urandom_range(0, 2) == 0;
      u = $urandom_range(0, 6) == 0;
      d = 16'($urandom);
      if ($urandom_range(0, 3) == 0) d = {13'h0, d[2:0]};
      if ($urandom_range(0, 7) == 0) d[15] = 1'b1;
      if (i == 700) begin
        @(posedge clk);
        #1;
        do_reset(pe, po, pu);
      end
      cyc(e, o, u, d, "rnd");
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/rpn_stack_alu.md
# rpn_stack_alu

Parametrised RPN calculation core: a DEPTH-entry operand stack of W-bit words with a 2-operand ALU, rising-edge command detection on Enter/Op/Undo, and one-level undo of the last stack-changing action. Sits between the debounced front-panel inputs (switches and buttons) and the display path (binary-to-BCD converter and 7-segment driver), which consume `Top`. It generalises the fixed A/B/OpCode calculator to a configurable-width, configurable-depth stack.

## Interface
- `W`, 16, operand and result width in bits (≥ 4).
- `DEPTH`, 8, stack entries (≥ 2).
- `clk` in 1: system clock; all state updates on rising edge.
- `resetN` in 1: asynchronous active-low reset.
- `Enter` in 1: debounced level; a rising edge pushes `DataIn`.
- `Op` in 1: debounced level; a rising edge executes opcode `DataIn[2:0]`.
- `Undo` in 1: debounced level; a rising edge reverts the last action.
- `DataIn` in W: operand or opcode.
- `Top` out W: top-of-stack value; 0 when the stack is empty.
- `Flags` out 4: {N, Z, C, V}.
- `Count` out $clog2(DEPTH+1): number of valid entries.
- `Error` out 1: set by the last command if it was rejected.

## Operation
- Edge detection: each input is registered every cycle. A command fires in the cycle where the input is 1 and its previous sample is 0.
- Priority when commands fire in the same cycle: Undo > Op > Enter. Lower-priority edges in that cycle are discarded; they do not fire later.
- Enter:
  - If `Count < DEPTH`: push `DataIn` and increment `Count`.
  - Otherwise (stack full): set `Error`; the stack is unchanged.
- Op: TOS is the top entry, NOS the entry below it. Opcodes:
  - 0 ADD: NOS + TOS.
  - 1 SUB: NOS − TOS.
  - 2 AND, 3 OR, 4 XOR.
  - 5 SWAP: exchanges NOS and TOS. `Count` is unchanged.
- Op result handling:
  - Arithmetic and logic ops pop two entries, push the result, and decrement `Count`.
  - `Count < 2` or opcode 6–7: set `Error`; the stack is unchanged.
- Arithmetic width rules: results are truncated to W bits.
  - ADD: C = carry out of bit W−1.
  - SUB: C = borrow (1 when NOS < TOS unsigned).
  - V = two's-complement signed overflow.
  - Logic ops and SWAP clear C and V.
- Flags:
  - N = `Top[W-1]`; Z = (`Top` == 0) and `Count` > 0. Both are recomputed every cycle from the registered stack.
  - C and V are held from the last successful Op and cleared by any successful Enter or Undo.
- Error: set by a rejected command, cleared by the next successful command. A rejected command leaves the undo history untouched.
- Undo (one level). The history records the last successful action: PUSH, OP (saved NOS, saved TOS, pre-op `Count`), or NONE.
  - Undo of PUSH: pop the entry.
  - Undo of OP: restore both saved operands and `Count`.
  - Undo after NONE, or a second consecutive Undo: set `Error`; no change.
  - A successful Undo sets the history to NONE.
  - C and V after Undo are 0.
- Entries at and above `Count` are don't-care; only `Count` defines validity.

## Timing
- Reset values (asserted asynchronously, released synchronously): `Count`=0, `Top`=0, `Flags`=4'b0000, `Error`=0, history NONE, edge registers 0.
- Input held high through reset release: no command fires until the input returns to 0 and rises again.
- Latency: a command edge sampled at clock edge k updates `Top`/`Count`/`Flags`/`Error` visibly after edge k. Every command is single-cycle.
- Throughput: one command per 2 cycles per input (an edge needs a 0 sample between).
- Reset mid-sequence: the stack and history are discarded entirely.

## Configuration
- `RPN_UNDO_EN` defined: history registers and Undo behave as specified above.
- `RPN_UNDO_EN` not defined:
  - History logic is not synthesised.
  - A rising edge on `Undo` is ignored: no state change and `Error` is unaffected.
  - Undo still wins priority, so Op/Enter edges in the same cycle are dropped.

## Test plan
- Reset with W=16, DEPTH=8 → `Count`=0, `Top`=0000, `Flags`=0000, `Error`=0. Then Enter FFFF, Enter 005A → `Count`=2, `Top`=005A.
- Continue: Op with `DataIn`=1 (SUB) → `Top`=FFA5, `Count`=1, N=1, Z=0, C=0, V=0. Then Undo (`RPN_UNDO_EN`) → `Count`=2, `Top`=005A, the entry below is FFFF, C=V=0. A second Undo → `Error`=1, stack unchanged.
- Enter 8000, Enter 8000, Op ADD → `Top`=0000, `Flags`={0,1,1,1}.
- DEPTH=4: five Enters of 0001..0005 → `Count`=4, `Top`=0004, `Error`=1 after the fifth. A following Enter of 0006 → `Count`=4, `Top`=0004, `Error`=1. Op ADD → `Top`=0007, `Error`=0.
- `Count`=1, Op ADD → `Error`=1, `Top` unchanged. Opcode 7 with `Count`=3 → `Error`=1.
- Enter, Op and Undo rising in the same cycle → only Undo acts. Enter held high through the next cycles → no further push. Without `RPN_UNDO_EN`, the same stimulus gives no change and `Error` stays at its previous value.
